// File: rtl/bridge_timer_if.sv
// bridge_timer_if: word-wide bridge bus between the CPU bridge (master) and a timer (slave)
`timescale 1ns/1ps
interface bridge_timer_if;
  logic        sel;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output sel, addr, we, wdata, input rdata);
  modport slave(input sel, addr, we, wdata, output rdata);
endinterface

// File: rtl/bridge_timer.sv
// bridge_timer: memory-mapped countdown timer with one-shot/auto-reload modes and masked irq
`timescale 1ns/1ps
module bridge_timer #(
  parameter int COUNT_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  bridge_timer_if.slave  bus,
  output logic           irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0]  ctrl, ctrl_nx;
  logic [COUNT_W-1:0] preset, count, count_nx;
  logic irq_flag, flag_nx;
  logic wr_ctrl, wr_preset, en, reload;
  logic unused_bits;
  assign wr_ctrl = bus.sel & bus.we & (bus.addr[3:2] == 2'd0);
  assign wr_preset = bus.sel & bus.we & (bus.addr[3:2] == 2'd1);
  assign en = ctrl[0];
  assign reload = ctrl[2:1] == 2'b01;
  assign irq = ctrl[3] & irq_flag;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata};
  always_comb begin
    state_nx = state;
    ctrl_nx = ctrl;
    count_nx = count;
    flag_nx = irq_flag;
    case (state)
      IDLE: state_nx = en ? LOAD : IDLE;
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        state_nx = !en ? IDLE : (count == '0) ? INT : CNT;
        count_nx = (en && count != '0) ? count - COUNT_W'(1) : count;
        flag_nx = irq_flag | (en && count == '0);
      end
      INT: begin
        state_nx = reload ? LOAD : IDLE;
        flag_nx = reload ? 1'b0 : irq_flag;
        ctrl_nx[0] = reload & ctrl[0];
      end
    endcase
    // Bus writes override FSM updates to CTRL and to the flag on the same edge
    if (wr_ctrl) ctrl_nx = bus.wdata[CTRL_W-1:0];
    if (wr_ctrl | wr_preset) flag_nx = 1'b0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nx;
      ctrl <= ctrl_nx;
      count <= count_nx;
      irq_flag <= flag_nx;
      if (wr_preset) preset <= bus.wdata[COUNT_W-1:0];
    end
  end
  always_comb
    bus.rdata = !bus.sel ? 32'd0 :
                bus.addr[3:2] == 2'd0 ? 32'(ctrl) :
                bus.addr[3:2] == 2'd1 ? 32'(preset) :
                bus.addr[3:2] == 2'd2 ? 32'(count) : 32'd0;
endmodule
